// File: rtl/shift_step_unit.sv
// Programmable multi-bit shifter stepped by a debounced pushbutton.
// Each accepted press performs n single-bit shifts, one per clock.
module shift_step_unit #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned IN_W       = 3,
  parameter int unsigned AMT_W      = 2,
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  data_in,
  input  logic             load,
  input  logic             enable,
  input  logic             step_btn,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic [7:0]       press_cnt,
  output logic             zero
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic          sync1_reg, sync2_reg;
  logic          level_reg, level_d_reg;
  logic [CW-1:0] deb_cnt_reg;
  logic          press;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [AMT_W-1:0] rem_reg, rem_next;
  logic             dir_reg, dir_next;
  logic [1:0]       mode_reg, mode_next;
  logic [AMT_W-1:0] n_amt;
  logic [WIDTH-1:0] load_value;

  assign load_value = WIDTH'(data_in);
  assign n_amt      = (amount == '0) ? AMT_W'(1) : amount;

  // Synchroniser plus debounce: level flips only after DEB_CYCLES differing samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      deb_cnt_reg <= '0;
    end else begin
      sync1_reg   <= step_btn;
      sync2_reg   <= sync1_reg;
      level_d_reg <= level_reg;
      if (sync2_reg != level_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          level_reg   <= sync2_reg;
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + CW'(1);
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  assign press = level_reg & ~level_d_reg;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic             left,
                                              input logic [1:0]       m);
    logic fill;
    if (left) begin
      fill   = (m == 2'b10) ? v[WIDTH-1] : 1'b0;
      shift1 = {v[WIDTH-2:0], fill};
    end else begin
      fill   = (m == 2'b01) ? v[WIDTH-1] : ((m == 2'b10) ? v[0] : 1'b0);
      shift1 = {fill, v[WIDTH-1:1]};
    end
  endfunction

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    dir_next   = dir_reg;
    mode_next  = mode_reg;
    if (load) begin
      state_next = IDLE;
      data_next  = load_value;
      cnt_next   = 8'd0;
      rem_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (press && enable && (mode != 2'b11)) begin
            dir_next  = dir;
            mode_next = mode;
            data_next = shift1(data_reg, dir, mode);
            cnt_next  = (cnt_reg == 8'd255) ? cnt_reg : cnt_reg + 8'd1;
            if (n_amt > AMT_W'(1)) begin
              state_next = SHIFT;
              rem_next   = n_amt - AMT_W'(1);
            end
          end
        end
        SHIFT: begin
          // Presses arriving here are intentionally dropped.
          data_next = shift1(data_reg, dir_reg, mode_reg);
          rem_next  = rem_reg - AMT_W'(1);
          if (rem_reg == AMT_W'(1)) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= load_value;
      cnt_reg   <= 8'd0;
      rem_reg   <= '0;
      dir_reg   <= 1'b0;
      mode_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      dir_reg   <= dir_next;
      mode_reg  <= mode_next;
    end
  end

  assign data_out  = data_reg;
  assign busy      = (state_reg == SHIFT);
  assign press_cnt = cnt_reg;
  assign zero      = (data_reg == '0);

endmodule

// File: doc/shift_step_unit.md
Name: shift_step_unit

Overview:
- Parametrised successor to the single-step right shifter on the Lab2 datapath.
- Holds a WIDTH-bit register loaded from an IN_W-bit operand.
- Each debounced press of a raw pushbutton shifts the register by a programmable amount, one bit position per clock.
- Supports left/right direction and logical, arithmetic or rotate mode. Feeds the top-level display/LED mux.

Parameters:
- WIDTH, 4, shift register width in bits (>=2).
- IN_W, 3, operand width; must satisfy 1 <= IN_W <= WIDTH; operand is zero-extended into WIDTH.
- AMT_W, 2, width of the shift-amount input.
- DEB_CYCLES, 250000, consecutive stable synchronised samples required before the debounced level changes (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset; also reloads the operand.
- data_in  in  IN_W  operand.
- load  in  1  synchronous reload of the operand (level).
- enable  in  1  accepts new presses when 1.
- step_btn  in  1  raw asynchronous pushbutton.
- dir  in  1  0 = right, 1 = left.
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 hold (no change).
- amount  in  AMT_W  positions per press; 0 is treated as 1.
- data_out  out  WIDTH  shift register contents.
- busy  out  1  high while a multi-bit shift is in progress.
- press_cnt  out  8  accepted presses since reset/load, saturating at 255.
- zero  out  1  data_out == 0.

Behaviour:
- Reset (clk edge with rst=1): data_out = zero-extend(data_in) sampled at that edge; busy=0; press_cnt=0; zero reflects the loaded value. Synchroniser, debounce counter and debounced level clear to 0; FSM goes to IDLE. Reset mid-shift aborts the shift immediately.
- Input path: step_btn passes through a 2-FF synchroniser. The debounced level toggles only after DEB_CYCLES consecutive samples differ from it; the counter restarts on any sample equal to the current level. A 1-cycle press pulse is generated on the debounced level's 0->1 edge.
- Press latency: press pulse appears 2 + DEB_CYCLES + 1 cycles after a clean step_btn rise; a held button yields exactly one pulse.
- FSM IDLE: on press pulse with enable=1, load=0 and mode!=11:
  - latch dir, mode and n = (amount==0 ? 1 : amount) into internal registers;
  - perform the first 1-bit shift at that same edge;
  - press_cnt++ (saturating);
  - if n>1, go to SHIFT with remaining = n-1.
  - Pulses with enable=0 or mode=11 are dropped and do not count.
- FSM SHIFT: busy=1; one 1-bit shift per cycle using the latched dir/mode; return to IDLE when remaining reaches 0. A press pulse during SHIFT is dropped; there is no queueing. busy is registered and high exactly n-1 cycles.
- 1-bit shift rules:
  - Right logical: MSB<-0.
  - Right arithmetic: MSB<-MSB.
  - Right rotate: MSB<-old LSB.
  - Left logical and left arithmetic: LSB<-0, identical.
  - Left rotate: LSB<-old MSB.
- load=1 (rst=0): same effect as reset on data_out and press_cnt; aborts SHIFT (busy->0). Debounce state is kept. load has priority over a simultaneous press pulse.
- Inputs change during SHIFT: changes to dir, mode and amount take no effect until the next press.
- Width boundaries: shifting more than WIDTH positions is legal. Logical/arithmetic modes saturate to 0 or all-sign; rotate wraps modulo WIDTH.

Test Plan:
- Reset/load (WIDTH=4, IN_W=3, DEB_CYCLES=4): rst with data_in=3'b101 -> data_out=4'b0101, busy=0, press_cnt=0; load with data_in=3'b011 mid-run -> data_out=4'b0011.
- Debounce: 3-cycle glitch on step_btn -> no shift. Clean press held 20 cycles -> exactly one shift at cycle 7 after the rise. Bounce train on release -> no extra pulse.
- Modes, amount=1, start 4'b1001: right logical -> 0100; right arithmetic -> 1100; right rotate -> 1100; left rotate -> 0011; left logical -> 0010; mode=11 -> unchanged, press_cnt unchanged.
- Multi-bit (amount=3, right rotate, start 4'b0001): busy high 2 cycles; data_out sequence 1000, 0100, 0010. A second press during busy is ignored and press_cnt increments by 1 only.
- Enable gating and saturation: press with enable=0 -> no change. 300 accepted presses -> press_cnt=255. Shift to 0 -> zero=1.
- Reset mid-shift: rst asserted on the 2nd SHIFT cycle -> next cycle data_out=zero-extend(data_in), busy=0, FSM idle.
